// File: rtl/bus_pkg.sv
// Shared definitions for the single-master, two-slave system bus:
// arbiter state type, bus widths and the slave address windows.
package bus_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 64;
    localparam int NUM_SLAVES = 2;

    // Slave 0: memory, 2K-word window 0x0000-0x07FF
    localparam logic [ADDR_W-1:0] BUS_S0_BASE = 16'h0000;
    localparam logic [ADDR_W-1:0] BUS_S0_MASK = 16'hF800;
    // Slave 1: factorial core, 512-word window 0x7000-0x71FF
    localparam logic [ADDR_W-1:0] BUS_S1_BASE = 16'h7000;
    localparam logic [ADDR_W-1:0] BUS_S1_MASK = 16'hFE00;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } bus_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Single-master arbiter: grants the bus one cycle after a request and
// releases it one cycle after the request drops.
module bus_arbiter
    import bus_pkg::*;
(
    input  logic clk,
    input  logic reset_n,   // synchronous, active-high despite the name
    input  logic m_req,
    output logic m_grant
);

    bus_state_t r_state;
    logic       r_grant;

    // Arbiter FSM with a registered grant that mirrors the GRANT state
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_req) begin
                        r_state <= GRANT;
                        r_grant <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!m_req) begin
                        r_state <= IDLE;
                        r_grant <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 1'b0;
                end
            endcase
        end
    end

    assign m_grant = r_grant;

endmodule

// File: rtl/bus.sv
// System bus top: arbitration, address decode, zero-latency forwarding of
// address/write controls and one-cycle-delayed read data return.
module bus
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE = BUS_S0_BASE,
    parameter logic [ADDR_W-1:0] S0_MASK = BUS_S0_MASK,
    parameter logic [ADDR_W-1:0] S1_BASE = BUS_S1_BASE,
    parameter logic [ADDR_W-1:0] S1_MASK = BUS_S1_MASK
)
(
    input  logic              clk,
    input  logic              reset_n,   // synchronous, active-high
    input  logic              m_req,
    input  logic              m_wr,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] s0_dout,
    input  logic [DATA_W-1:0] s1_dout,
    output logic              m_grant,
    output logic [DATA_W-1:0] m_din,
    output logic              s0_sel,
    output logic              s1_sel,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wr,
    output logic [DATA_W-1:0] s_din
);

    localparam logic [ADDR_W-1:0] BASES [NUM_SLAVES] = '{S0_BASE, S1_BASE};
    localparam logic [ADDR_W-1:0] MASKS [NUM_SLAVES] = '{S0_MASK, S1_MASK};

    logic                  w_grant;
    logic [NUM_SLAVES-1:0] w_hit;
    logic [NUM_SLAVES-1:0] w_sel;
    logic [NUM_SLAVES-1:0] r_sel;

    bus_arbiter u_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .m_req   (m_req),
        .m_grant (w_grant)
    );

    // Window match per slave; selects only assert while the master owns the bus
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
            assign w_hit[gi] = ((m_addr & MASKS[gi]) == BASES[gi]);
            assign w_sel[gi] = w_hit[gi] & w_grant;
        end
    endgenerate

    assign m_grant = w_grant;
    assign s0_sel  = w_sel[0];
    assign s1_sel  = w_sel[1];

    // Pass-through to slaves while granted, driven to zero otherwise
    always_comb begin
        s_addr = '0;
        s_wr   = 1'b0;
        s_din  = '0;
        if (w_grant) begin
            s_addr = m_addr;
            s_wr   = m_wr;
            s_din  = m_dout;
        end
    end

    // Remember which slave was addressed so its synchronous read data is routed next cycle
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_sel <= '0;
        end else begin
            r_sel <= w_sel;
        end
    end

    // Read return mux; unmapped or idle cycles return zero
    always_comb begin
        m_din = '0;
        case (r_sel)
            2'b01:   m_din = s0_dout;
            2'b10:   m_din = s1_dout;
            default: m_din = '0;
        endcase
    end

endmodule

// File: tb/tb_bus.sv
// Testbench for bus: directed vector table followed by randomized traffic
// checked against a behavioural model of the bus.
module tb_bus;

    logic        clk;
    logic        reset_n;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic [63:0] s0_dout;
    logic [63:0] s1_dout;
    logic        m_grant;
    logic [63:0] m_din;
    logic        s0_sel;
    logic        s1_sel;
    logic [15:0] s_addr;
    logic        s_wr;
    logic [63:0] s_din;

    int vectors;
    int miscompares;

    // Behavioural model state: does the master own the bus, and which slave
    // (0 = none, 1 = memory, 2 = factorial core) was addressed last cycle.
    bit model_owned;
    int model_last_slave;

    typedef struct {
        logic        rst;
        logic        req;
        logic        wr;
        logic [15:0] addr;
        logic [63:0] dout;
        logic        eg;
        logic        es0;
        logic        es1;
        logic [15:0] ea;
        logic        ewr;
        logic [63:0] ed;
        logic [63:0] em;
    } vec_t;

    vec_t tbl [15];

    bus dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m_req   (m_req),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_dout  (m_dout),
        .s0_dout (s0_dout),
        .s1_dout (s1_dout),
        .m_grant (m_grant),
        .m_din   (m_din),
        .s0_sel  (s0_sel),
        .s1_sel  (s1_sel),
        .s_addr  (s_addr),
        .s_wr    (s_wr),
        .s_din   (s_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic req, logic wr, logic [15:0] addr,
                                logic [63:0] dout, logic eg, logic es0, logic es1,
                                logic [15:0] ea, logic ewr, logic [63:0] ed,
                                logic [63:0] em);
        vec_t v;
        v.rst = rst; v.req = req; v.wr = wr; v.addr = addr; v.dout = dout;
        v.eg = eg; v.es0 = es0; v.es1 = es1; v.ea = ea; v.ewr = ewr;
        v.ed = ed; v.em = em;
        return v;
    endfunction

    task automatic compare(input string tag, input logic eg, input logic es0,
                           input logic es1, input logic [15:0] ea, input logic ewr,
                           input logic [63:0] ed, input logic [63:0] em);
        vectors++;
        if (m_grant !== eg || s0_sel !== es0 || s1_sel !== es1 || s_addr !== ea ||
            s_wr !== ewr || s_din !== ed || m_din !== em) begin
            miscompares++;
            $display("FAIL %s got grant=%b s0=%b s1=%b addr=%h wr=%b din=%h mdin=%h want grant=%b s0=%b s1=%b addr=%h wr=%b din=%h mdin=%h",
                     tag, m_grant, s0_sel, s1_sel, s_addr, s_wr, s_din, m_din,
                     eg, es0, es1, ea, ewr, ed, em);
        end else begin
            $display("ok   %s grant=%b s0=%b s1=%b addr=%h wr=%b mdin=%h",
                     tag, m_grant, s0_sel, s1_sel, s_addr, s_wr, m_din);
        end
    endtask

    // Which slave the model says an address belongs to (0 = unmapped)
    function automatic int slave_of(logic [15:0] a);
        if (a <= 16'h07FF) return 1;
        if (a >= 16'h7000 && a <= 16'h71FF) return 2;
        return 0;
    endfunction

    // Advance the model across one rising edge using the inputs currently applied
    task automatic clock_model();
        bit owned_now;
        int hit;
        owned_now = model_owned;
        hit       = owned_now ? slave_of(m_addr) : 0;
        @(posedge clk);
        if (reset_n) begin
            model_owned      = 1'b0;
            model_last_slave = 0;
        end else begin
            model_owned      = m_req;
            model_last_slave = hit;
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        int          hit;
        logic [63:0] em;
        hit = model_owned ? slave_of(m_addr) : 0;
        if (model_last_slave == 1)      em = s0_dout;
        else if (model_last_slave == 2) em = s1_dout;
        else                            em = 64'h0;
        compare(tag, model_owned, hit == 1, hit == 2,
                model_owned ? m_addr : 16'h0, model_owned ? m_wr : 1'b0,
                model_owned ? m_dout : 64'h0, em);
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        model_owned      = 1'b0;
        model_last_slave = 0;

        reset_n = 1'b1;
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_addr  = 16'h0;
        m_dout  = 64'h0;
        s0_dout = 64'h1111_1111;
        s1_dout = 64'h2222_2222;

        //           rst  req  wr  addr      dout      grant s0  s1  s_addr    wr  s_din     m_din
        tbl[0]  = mk(1'b1,1'b0,1'b0,16'h0000,64'd0,    1'b0,1'b0,1'b0,16'h0000,1'b0,64'd0,    64'h0);
        tbl[1]  = mk(1'b0,1'b1,1'b1,16'h0010,64'd10,   1'b0,1'b0,1'b0,16'h0000,1'b0,64'd0,    64'h0);
        tbl[2]  = mk(1'b0,1'b1,1'b1,16'h0010,64'd10,   1'b1,1'b1,1'b0,16'h0010,1'b1,64'd10,   64'h0);
        tbl[3]  = mk(1'b0,1'b1,1'b0,16'h7010,64'h5A5A, 1'b1,1'b0,1'b1,16'h7010,1'b0,64'h5A5A, 64'h1111_1111);
        tbl[4]  = mk(1'b0,1'b1,1'b0,16'h0010,64'h5A5A, 1'b1,1'b1,1'b0,16'h0010,1'b0,64'h5A5A, 64'h2222_2222);
        tbl[5]  = mk(1'b0,1'b1,1'b0,16'h4000,64'h5A5A, 1'b1,1'b0,1'b0,16'h4000,1'b0,64'h5A5A, 64'h1111_1111);
        tbl[6]  = mk(1'b0,1'b1,1'b0,16'h4000,64'h5A5A, 1'b1,1'b0,1'b0,16'h4000,1'b0,64'h5A5A, 64'h0);
        tbl[7]  = mk(1'b0,1'b0,1'b0,16'h7010,64'h5A5A, 1'b1,1'b0,1'b1,16'h7010,1'b0,64'h5A5A, 64'h0);
        tbl[8]  = mk(1'b0,1'b0,1'b0,16'h7010,64'h5A5A, 1'b0,1'b0,1'b0,16'h0000,1'b0,64'd0,    64'h2222_2222);
        tbl[9]  = mk(1'b0,1'b0,1'b0,16'h7010,64'h5A5A, 1'b0,1'b0,1'b0,16'h0000,1'b0,64'd0,    64'h0);
        tbl[10] = mk(1'b0,1'b1,1'b0,16'h7010,64'h5A5A, 1'b0,1'b0,1'b0,16'h0000,1'b0,64'd0,    64'h0);
        tbl[11] = mk(1'b0,1'b1,1'b0,16'h7010,64'h5A5A, 1'b1,1'b0,1'b1,16'h7010,1'b0,64'h5A5A, 64'h0);
        tbl[12] = mk(1'b1,1'b1,1'b0,16'h7010,64'h5A5A, 1'b1,1'b0,1'b1,16'h7010,1'b0,64'h5A5A, 64'h2222_2222);
        tbl[13] = mk(1'b0,1'b1,1'b0,16'h7010,64'h5A5A, 1'b0,1'b0,1'b0,16'h0000,1'b0,64'd0,    64'h0);
        tbl[14] = mk(1'b0,1'b1,1'b0,16'h7010,64'h5A5A, 1'b1,1'b0,1'b1,16'h7010,1'b0,64'h5A5A, 64'h0);

        // Two reset cycles bring the design into a known state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Directed table: outputs checked within the cycle the inputs are applied
        for (int i = 0; i < 15; i++) begin
            reset_n = tbl[i].rst;
            m_req   = tbl[i].req;
            m_wr    = tbl[i].wr;
            m_addr  = tbl[i].addr;
            m_dout  = tbl[i].dout;
            #1;
            compare($sformatf("tbl%0d", i), tbl[i].eg, tbl[i].es0, tbl[i].es1,
                    tbl[i].ea, tbl[i].ewr, tbl[i].ed, tbl[i].em);
            clock_model();
        end

        // Randomized traffic biased toward windows and their boundaries
        for (int n = 0; n < 400; n++) begin
            int region;
            reset_n = ($urandom_range(0, 31) == 0);
            m_req   = ($urandom_range(0, 3) != 0);
            m_wr    = $urandom_range(0, 1);
            region  = $urandom_range(0, 3);
            case (region)
                0: m_addr = 16'($urandom_range(16'h0000, 16'h07FF));
                1: m_addr = 16'($urandom_range(16'h7000, 16'h71FF));
                2: begin
                    case ($urandom_range(0, 3))
                        0: m_addr = 16'h07FF;
                        1: m_addr = 16'h0800;
                        2: m_addr = 16'h6FFF;
                        default: m_addr = 16'h7200;
                    endcase
                end
                default: m_addr = 16'($urandom);
            endcase
            m_dout  = {$urandom, $urandom};
            s0_dout = {$urandom, $urandom};
            s1_dout = {$urandom, $urandom};
            #1;
            check_model($sformatf("rnd%0d", n));
            clock_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
